// File: rtl/gpi_pkg.sv
// Shared definitions for the general-purpose input capture peripheral.
// Register address map and debounce counter width derivation.
package gpi_pkg;

    localparam logic [1:0] GPI_LEVEL   = 2'd0;
    localparam logic [1:0] GPI_STATUS  = 2'd1;
    localparam logic [1:0] GPI_MASK    = 2'd2;
    localparam logic [1:0] GPI_EDGESEL = 2'd3;

    localparam int unsigned GPI_BUS_W = 32;

    // Counter only has to hold 0 .. deb_cycles-1
    function automatic int unsigned deb_cnt_w(input int unsigned deb_cycles);
        return (deb_cycles > 2) ? $clog2(deb_cycles) : 1;
    endfunction

endpackage

// File: rtl/gpi_debounce.sv
// Single-bit two-flop synchronizer followed by a debouncer.
// GPI_DEBOUNCE_EN: when defined, level only follows s2 after DEB_CYCLES
// consecutive mismatching cycles; when undefined, level follows s2 every cycle.
// level_nxt_c exposes the value level takes on the coming edge so the parent
// can flag edges on the same edge that level toggles.
module gpi_debounce
    import gpi_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic level_nxt_c
);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_cfg
        $error("gpi_debounce: DEB_CYCLES must be within 2..255");
    end

    logic s1;
    logic s2;

`ifdef GPI_DEBOUNCE_EN
    localparam int unsigned   CW       = deb_cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;

    // Count consecutive mismatches; commit s2 once the run is long enough
    always_comb begin
        level_nxt_c = level;
        cnt_nxt_c   = '0;
        if (s2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt_c = s2;
            end else begin
                cnt_nxt_c = cnt + CW'(1);
            end
        end
    end

    // Mismatch counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end
`else
    // Without debounce the level simply tracks the synchronized pin
    always_comb begin
        level_nxt_c = s2;
    end
`endif

    // Synchronizer flops and debounced level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            level <= level_nxt_c;
        end
    end

endmodule

// File: rtl/gpi_capture.sv
// General-purpose input capture: per-pin sync/debounce, edge detect,
// sticky W1C status, per-bit interrupt mask and edge select.
// GPI_DEBOUNCE_EN selects whether the per-pin debounce counters exist.
module gpi_capture
    import gpi_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           a,
    input  logic                 we,
    input  logic [GPI_BUS_W-1:0] wd,
    input  logic [W-1:0]         pins,
    output logic [GPI_BUS_W-1:0] rd,
    output logic                 irq
);

    if (W < 1 || W > GPI_BUS_W) begin : g_bad_width
        $error("gpi_capture: W must be within 1..32");
    end

    logic [W-1:0] level;
    logic [W-1:0] level_nxt_c;
    logic [W-1:0] status_q;
    logic [W-1:0] mask_q;
    logic [W-1:0] edgesel_q;

    logic [W-1:0] wd_w;
    logic [W-1:0] set_c;
    logic [W-1:0] w1c_c;
    logic [W-1:0] status_nxt_c;
    logic [W-1:0] mask_nxt_c;
    logic [W-1:0] edgesel_nxt_c;

    assign wd_w = wd[W-1:0];

    for (genvar i = 0; i < W; i++) begin : g_pin
        gpi_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .pin         (pins[i]),
            .level       (level[i]),
            .level_nxt_c (level_nxt_c[i])
        );
    end

    // Edge flags, W1C clear (set wins) and RW register updates
    always_comb begin
        set_c         = (level_nxt_c & ~level & ~edgesel_q)
                      | (~level_nxt_c & level & edgesel_q);
        w1c_c         = '0;
        mask_nxt_c    = mask_q;
        edgesel_nxt_c = edgesel_q;
        if (we) begin
            case (a)
                GPI_STATUS:  w1c_c         = wd_w;
                GPI_MASK:    mask_nxt_c    = wd_w;
                GPI_EDGESEL: edgesel_nxt_c = wd_w;
                default:     ;
            endcase
        end
        status_nxt_c = (status_q & ~w1c_c) | set_c;
    end

    // Register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q  <= '0;
            mask_q    <= '0;
            edgesel_q <= '0;
        end else begin
            status_q  <= status_nxt_c;
            mask_q    <= mask_nxt_c;
            edgesel_q <= edgesel_nxt_c;
        end
    end

    // Combinational read mux, unimplemented upper bits read zero
    always_comb begin
        rd = '0;
        case (a)
            GPI_LEVEL:   rd = GPI_BUS_W'(level);
            GPI_STATUS:  rd = GPI_BUS_W'(status_q);
            GPI_MASK:    rd = GPI_BUS_W'(mask_q);
            GPI_EDGESEL: rd = GPI_BUS_W'(edgesel_q);
            default:     rd = '0;
        endcase
    end

    // Level interrupt from registered state only
    assign irq = |(status_q & mask_q);

endmodule

// File: tb/tb_gpi_capture.sv
// Self-checking bench for gpi_capture: directed steps plus random pin and
// register traffic against a history-based reference model.
module tb_gpi_capture;
    import gpi_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned DEB = 4;
`ifdef GPI_DEBOUNCE_EN
    localparam int unsigned D = DEB;
`else
    localparam int unsigned D = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    a;
    logic          we;
    logic [31:0]   wd;
    logic [W-1:0]  pins;
    logic [31:0]   rd;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: level flips when the last D synchronized samples all
    // disagree with it.
    logic [W-1:0] m_s1, m_s2, m_level, m_status, m_mask, m_edgesel;
    logic [W-1:0] m_hist[$];

    gpi_capture #(.W(W), .DEB_CYCLES(DEB)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .we   (we),
        .wd   (wd),
        .pins (pins),
        .rd   (rd),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_status = '0; m_mask = '0; m_edgesel = '0;
        m_hist = {};
        for (int i = 0; i < int'(D); i++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] flip;
        logic [W-1:0] set;
        logic [W-1:0] w1c;
        if (!rst) begin
            model_reset();
            return;
        end
        m_hist.push_back(m_s2);
        void'(m_hist.pop_front());
        flip = '1;
        foreach (m_hist[i]) flip &= m_hist[i] ^ m_level;
        set = (flip & ~m_level & ~m_edgesel) | (flip & m_level & m_edgesel);
        w1c = (we && a == GPI_STATUS) ? wd : '0;
        m_status = (m_status & ~w1c) | set;
        if (we && a == GPI_MASK)    m_mask    = wd;
        if (we && a == GPI_EDGESEL) m_edgesel = wd;
        m_level = m_level ^ flip;
        m_s2 = m_s1;
        m_s1 = pins;
    endtask

    function automatic logic [31:0] m_reg(input int i);
        case (i)
            0:       return m_level;
            1:       return m_status;
            2:       return m_mask;
            default: return m_edgesel;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read all registers and irq against the model (takes 4 ns)
    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            #1;
            chk($sformatf("%s/reg%0d", tag, i), rd, m_reg(i));
        end
        chk({tag, "/irq"}, {31'b0, irq}, {31'b0, |(m_status & m_mask)});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0;
        check_all(tag);
    endtask

    task automatic write(input logic [1:0] addr, input logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        tick("wr");
    endtask

    task automatic rdreg(input logic [1:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = rd;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b0; a = '0; we = 1'b0; wd = '0; pins = '0;
        model_reset();

        // Reset state
        tick("rst"); tick("rst");
        rst = 1'b1;
        tick("post_rst");
        rdreg(GPI_STATUS, v);  chk("rst_status", v, 32'h0);
        rdreg(GPI_MASK, v);    chk("rst_mask", v, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // LEVEL is read-only
        write(GPI_LEVEL, 32'hFFFF_FFFF);
        rdreg(GPI_LEVEL, v);   chk("level_ro", v, 32'h0);

        // Pin-to-level latency and W1C
        write(GPI_MASK, 32'h1);
        write(GPI_EDGESEL, 32'h0);
        pins[0] = 1'b1;
        repeat (D + 1) tick("lat");
        rdreg(GPI_LEVEL, v);   chk("lat_early", v, 32'h0);
        tick("lat");
        rdreg(GPI_LEVEL, v);   chk("lat_level", v, 32'h1);
        rdreg(GPI_STATUS, v);  chk("lat_status", v, 32'h1);
        chk("lat_irq", {31'b0, irq}, 32'h1);
        write(GPI_STATUS, 32'h1);
        rdreg(GPI_STATUS, v);  chk("w1c_status", v, 32'h0);
        chk("w1c_irq", {31'b0, irq}, 32'h0);

        // Short pulse is filtered, full-length pulse passes once
        pins[3] = 1'b1;
        repeat (D - 1) tick("glitch");
        pins[3] = 1'b0;
        repeat (2 * D + 4) tick("glitch");
        rdreg(GPI_LEVEL, v);   chk("glitch_level", v & 32'h8, 32'h0);
        rdreg(GPI_STATUS, v);  chk("glitch_status", v & 32'h8, 32'h0);
        pins[3] = 1'b1;
        repeat (D) tick("pulse");
        pins[3] = 1'b0;
        repeat (2 * D + 4) tick("pulse");
        rdreg(GPI_STATUS, v);  chk("pulse_status", v & 32'h8, 32'h8);
        rdreg(GPI_LEVEL, v);   chk("pulse_level", v & 32'h8, 32'h0);

        // Falling-edge select with interrupt masked
        write(GPI_STATUS, 32'hFFFF_FFFF);
        write(GPI_MASK, 32'h0);
        write(GPI_EDGESEL, 32'h4);
        pins[2] = 1'b1;
        repeat (2 * D + 4) tick("fall");
        rdreg(GPI_STATUS, v);  chk("fall_rise_ignored", v, 32'h0);
        pins[2] = 1'b0;
        repeat (2 * D + 4) tick("fall");
        rdreg(GPI_STATUS, v);  chk("fall_status", v, 32'h4);
        chk("fall_irq_masked", {31'b0, irq}, 32'h0);

        // Set and W1C on the same edge: set wins
        write(GPI_STATUS, 32'hFFFF_FFFF);
        write(GPI_EDGESEL, 32'h0);
        write(GPI_MASK, 32'h2);
        pins[1] = 1'b1;
        repeat (D + 1) tick("race");
        write(GPI_STATUS, 32'h2);
        rdreg(GPI_STATUS, v);  chk("race_status", v, 32'h2);
        chk("race_irq", {31'b0, irq}, 32'h1);

        // Asynchronous reset mid-debounce, pins held high through reset
        pins[6] = 1'b1;
        tick("pre_arst"); tick("pre_arst");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_irq", {31'b0, irq}, 32'h0);
        check_all("arst");
        tick("arst"); tick("arst");
        rst = 1'b1;
        repeat (D + 4) tick("after_arst");
        rdreg(GPI_STATUS, v);  chk("arst_status", v, 32'h43);
        rdreg(GPI_LEVEL, v);   chk("arst_level", v, 32'h43);

        // Random pins and register traffic
        for (int c = 0; c < 400; c++) begin
            pins = pins ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(3) == 0) begin
                a  = 2'($urandom_range(3));
                wd = $urandom;
                we = 1'b1;
            end
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpi_capture.md
# gpi_capture

General-purpose input capture peripheral. It is the input-direction counterpart of the GPIO output path on the same 2-bit-address memory-mapped peripheral bus. Each input pin is synchronized, optionally debounced, and edge-detected. Selected edges latch into sticky write-1-to-clear status bits, which drive a level interrupt to the CPU.

## Interface
Parameters:
- `W`, default 32: number of input pins.
- `DEB_CYCLES`, default 4: consecutive mismatching cycles required before the debounced level changes. Legal range is 2 to 255.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge triggered.
- `rst`, input, 1: asynchronous active-low reset.
- `a`, input, 2: register address.
- `we`, input, 1: write enable, sampled on the `clk` rising edge.
- `wd`, input, 32: write data.
- `pins`, input, `W`: raw asynchronous input pins.
- `rd`, output, 32: read data, combinational from `a`. Bits above `W` read 0.
- `irq`, output, 1: level interrupt, equal to OR over (`status` & `mask`).

## Operation
Register map:
- 0 LEVEL (RO): debounced pin levels. Writes are ignored.
- 1 STATUS (W1C): sticky edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 2 MASK (RW): interrupt enable per bit.
- 3 EDGESEL (RW): per bit, 0 selects rising edge and 1 selects falling edge.

Per-bit pipeline:
- Two-flop synchronizer, `s1` then `s2`.
- Debouncer produces `level`.
- Edge detect compares the `level` update against the old `level`.

Debounce rules:
- The counter increments on each cycle where `s2` != `level`.
- The counter resets to 0 on any cycle where `s2` == `level`.
- When the counter reaches `DEB_CYCLES`-1 and `s2` still differs, then on that edge `level` <= `s2` and the counter resets to 0.
- Glitches shorter than `DEB_CYCLES` cycles at `s2` never reach `level`.

Status rules:
- A bit sets on the same edge that `level` toggles in the direction selected by EDGESEL.
- If a set event and a W1C clear of the same bit occur on the same cycle, set wins.
- An EDGESEL write takes effect for transitions on the following cycles. It does not retroactively set or clear status.

Reset values:
- `s1`, `s2`, `level`, counters, STATUS, MASK and EDGESEL all reset to 0.
- Therefore `irq` = 0 and `rd` = 0 for addresses 0 to 2.
- A pin held high through reset produces a rising-edge flag once it passes debounce after reset deasserts.
- Asserting reset mid-debounce discards the partial count.

Width rules:
- Only `wd[W-1:0]` is used.
- Register bits at index `W` and above are not implemented and read 0.

## Timing
- Register writes update on the rising edge where `we` = 1. The new value is visible on `rd` in the following cycle.
- Reads are combinational, with zero latency.
- Pin-to-level latency with `DEB_CYCLES`=4, for a pin change setting up before edge 0:
  - `s1` changes at edge 0 and `s2` at edge 1.
  - Mismatch is counted at edges 2, 3 and 4.
  - `level` and STATUS update at edge 5.
  - `irq` rises after edge 5.
- In general, latency is 1 + `DEB_CYCLES` edges after `s1` captures the change.
- `irq` is combinational from registered STATUS and MASK, so it is glitch-free relative to `clk`.
- After a W1C write at edge n, `irq` falls after edge n, unless the same bit re-sets at edge n.

## Configuration
- `GPI_DEBOUNCE_EN` defined: debounce counters are instantiated as described above.
- `GPI_DEBOUNCE_EN` undefined:
  - No counters exist; `level` <= `s2` every cycle and `DEB_CYCLES` is ignored.
  - A pin change before edge 0 reaches `level` and STATUS at edge 2.
  - Register map and all other behaviour are unchanged.

## Structure
- Shared package `gpi_pkg` holds the register address constants:
  - `GPI_LEVEL`=2'd0, `GPI_STATUS`=2'd1, `GPI_MASK`=2'd2, `GPI_EDGESEL`=2'd3.
  - The counter width derivation from `DEB_CYCLES`.
- One sub-module, `gpi_debounce`: single-bit synchronizer plus debouncer, with output `level`. It is instantiated `W` times with a generate loop.
- Edge detect, registers and the read mux live in `gpi_capture`.

## Test plan
- Reset with all pins 0 → every register reads 0 and `irq`=0. Write 0xFFFF_FFFF to LEVEL → it still reads 0.
- MASK=0x1, EDGESEL=0, pin0 driven 0→1 before edge 0 (`DEB_CYCLES`=4) → LEVEL=0x1 and STATUS=0x1 after edge 5, `irq`=1. Write STATUS=0x1 → STATUS=0 and `irq`=0 next cycle.
- 3-cycle high pulse on pin3 → LEVEL and STATUS remain 0. A 4-cycle pulse → LEVEL bit 3 toggles 1 then 0, and STATUS bit 3 sets once.
- EDGESEL=0x4, pin2 rises then falls → STATUS bit 2 sets only on the fall. With MASK=0, `irq` stays 0 while STATUS=0x4.
- W1C of STATUS bit 1 issued on the same edge pin1's qualifying edge lands → STATUS bit 1 remains 1.
- Build without `GPI_DEBOUNCE_EN`, pin5 rises before edge 0 → LEVEL bit 5 and STATUS bit 5 set at edge 2. Assert `rst` low asynchronously mid-operation → all registers return to 0 immediately.
